// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the round-robin register write arbiter.
package reg_arb_pkg;

  localparam int REG_W       = 8;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    ACK     = 3'd2,
    CLEAR   = 3'd3,
    CLR_ACK = 3'd4
  } arb_state_e;

  localparam arb_state_e       RST_STATE = IDLE;
  localparam logic [REG_W-1:0] RST_DATA  = 8'h00;

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one load-enabled register among NUM_REQ requesters.
// Optional sticky ownership is enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*REG_W-1:0] wdata,
  input  logic                     clr_req,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       lock,
`endif
  output logic [NUM_REQ-1:0]       ack,
  output logic                     clr_ack,
  output logic                     reg_load,
  output logic [REG_W-1:0]         reg_data,
  output logic                     reg_clr,
  input  logic [REG_W-1:0]         reg_q,
  output logic [REG_W-1:0]         rdata,
  output logic [PTR_W-1:0]         owner,
  output logic                     busy
);

  arb_state_e       state;
  arb_state_e       next_state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] pick_sel;
  logic             pick_valid;
  logic [PTR_W-1:0] grant_sel;
  logic             grant_valid;
  logic [REG_W-1:0] grant_data;
  logic [REG_W-1:0] data_q;
  logic             hold_ptr;

  rr_picker #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_picker (
    .req  (req),
    .ptr  (rr_ptr),
    .sel  (pick_sel),
    .valid(pick_valid)
  );

`ifdef REG_ARB_LOCK_EN
  logic locked;

  // While locked only the current owner may be granted.
  always_comb begin
    if (locked) begin
      grant_valid = req[owner];
      grant_sel   = owner;
    end else begin
      grant_valid = pick_valid;
      grant_sel   = pick_sel;
    end
    hold_ptr = lock[owner];
  end

  // Lock is set/released on ACK, or released when an idle owner stops asking.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      locked <= 1'b0;
    end else if (state == ACK) begin
      locked <= lock[owner];
    end else if (state == IDLE && locked && !clr_req && !req[owner] && !lock[owner]) begin
      locked <= 1'b0;
    end
  end
`else
  assign grant_valid = pick_valid;
  assign grant_sel   = pick_sel;
  assign hold_ptr    = 1'b0;
`endif

  // Select the granted requester's data lane.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_sel == PTR_W'(i)) begin
        grant_data = wdata[i*REG_W +: REG_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state <= RST_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a pending clear outranks any write.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clr_req) begin
          next_state = CLEAR;
        end else if (grant_valid) begin
          next_state = WRITE;
        end else begin
          next_state = IDLE;
        end
      end
      WRITE:   next_state = ACK;
      ACK:     next_state = IDLE;
      CLEAR:   next_state = CLR_ACK;
      CLR_ACK: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; reset also clears the shared register.
  always_comb begin
    ack      = '0;
    clr_ack  = 1'b0;
    reg_load = 1'b0;
    reg_clr  = async_rst;
    busy     = 1'b1;
    case (state)
      IDLE:  busy = 1'b0;
      WRITE: reg_load = 1'b1;
      ACK: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          ack[i] = (owner == PTR_W'(i));
        end
      end
      CLEAR:   reg_clr = 1'b1;
      CLR_ACK: clr_ack = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Grant bookkeeping: data is captured at the grant edge, pointer moves on ACK.
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      owner  <= '0;
      rr_ptr <= '0;
      data_q <= RST_DATA;
    end else begin
      if (state == IDLE && !clr_req && grant_valid) begin
        owner  <= grant_sel;
        data_q <= grant_data;
      end
      if (state == ACK && !hold_ptr) begin
        rr_ptr <= PTR_W'(wrap_inc(int'(owner), NUM_REQ));
      end
    end
  end

  assign reg_data = data_q;
  assign rdata    = reg_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: transaction-level model plus directed scenarios.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int K_IDLE = 0, K_WRITE = 1, K_ACK = 2, K_POST = 3, K_CLR = 4, K_CLRACK = 5;

  logic           clk = 1'b0;
  logic           async_rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] wdata;
  logic           clr_req;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0]   lock;
  wire  [N-1:0]   lock_v = lock;
`else
  wire  [N-1:0]   lock_v = '0;
`endif
  logic [N-1:0]   ack;
  logic           clr_ack, reg_load, reg_clr, busy;
  logic [7:0]     reg_data, reg_q, rdata;
  logic [PW-1:0]  owner;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N-1:0] ack_seen = '0;
  logic         clr_ack_seen = 1'b0;

  always #5 clk = ~clk;

  reg_write_arbiter dut (
    .clk(clk), .async_rst(async_rst), .req(req), .wdata(wdata), .clr_req(clr_req),
`ifdef REG_ARB_LOCK_EN
    .lock(lock),
`endif
    .ack(ack), .clr_ack(clr_ack), .reg_load(reg_load), .reg_data(reg_data),
    .reg_clr(reg_clr), .reg_q(reg_q), .rdata(rdata), .owner(owner), .busy(busy)
  );

  // The shared 8-bit register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reg_clr) reg_q <= 8'h00;
    else if (reg_load) reg_q <= reg_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: each cycle has a kind; a transaction books its follow-on cycles in a queue.
  int         m_kind = K_IDLE;
  int         m_sched[$];
  int         m_ptr = 0, m_own = 0, m_sel;
  logic [7:0] m_dat = 8'h00, m_q = 8'h00;
  bit         m_locked = 1'b0, m_in_rst = 1'b0;

  always begin
    @(posedge clk or posedge async_rst);
    if (async_rst) begin
      if (m_in_rst) m_q = 8'h00;
      m_in_rst = 1'b1;
      m_sched.delete();
      m_kind = K_IDLE; m_ptr = 0; m_own = 0; m_dat = 8'h00; m_locked = 1'b0;
    end else begin
      m_in_rst = 1'b0;
      case (m_kind)
        K_WRITE: m_q = m_dat;
        K_CLR:   m_q = 8'h00;
        K_ACK: begin
          if (lock_v[m_own]) m_locked = 1'b1;
          else begin
            m_locked = 1'b0;
            m_ptr = (m_own + 1) % N;
          end
        end
        default: ;
      endcase
      m_sel = -1;
      if (m_sched.size() > 0) begin
        m_kind = m_sched.pop_front();
      end else if (clr_req) begin
        m_kind = K_CLR;
        m_sched.push_back(K_CLRACK);
        m_sched.push_back(K_POST);
      end else if (m_locked) begin
        if (req[m_own]) m_sel = m_own;
        else begin
          if (!lock_v[m_own]) m_locked = 1'b0;
          m_kind = K_IDLE;
        end
      end else begin
        for (int k = N - 1; k >= 0; k--) if (req[(m_ptr + k) % N]) m_sel = (m_ptr + k) % N;
        if (m_sel < 0) m_kind = K_IDLE;
      end
      if (m_sel >= 0) begin
        m_own  = m_sel;
        m_dat  = wdata[m_sel*8 +: 8];
        m_kind = K_WRITE;
        m_sched.push_back(K_ACK);
        m_sched.push_back(K_POST);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always begin
    logic [N-1:0] exp_ack;
    @(negedge clk);
    exp_ack = (m_kind == K_ACK) ? (N'(1) << m_own) : '0;
    chk("ack", ack, exp_ack);
    chk("clr_ack", clr_ack, m_kind == K_CLRACK);
    chk("reg_load", reg_load, m_kind == K_WRITE);
    chk("reg_data", reg_data, m_dat);
    chk("reg_clr", reg_clr, async_rst || m_kind == K_CLR);
    chk("busy", busy, m_kind == K_WRITE || m_kind == K_ACK || m_kind == K_CLR || m_kind == K_CLRACK);
    chk("owner", owner, m_own);
    chk("rdata", rdata, m_q);
    ack_seen     = ack;
    clr_ack_seen = clr_ack;
  end

  // One cycle; requesters drop their level request after seeing its done pulse.
  task automatic tick();
    @(posedge clk);
    #2;
    req = req & ~ack_seen;
    if (clr_ack_seen) clr_req = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    async_rst = 1'b1;
    req = '0;
    clr_req = 1'b0;
    tick_n(n);
    async_rst = 1'b0;
  endtask

  initial begin
    int acks[$];
    int owners[$];
    int last_n;
    int zeros;
    async_rst = 1'b1; req = '0; clr_req = 1'b0; wdata = '0;
`ifdef REG_ARB_LOCK_EN
    lock = '0;
`endif
    // Reset state
    tick_n(2);
    at_neg();
    chk("rst_busy", busy, 1'b0);
    chk("rst_load", reg_load, 1'b0);
    chk("rst_ack", ack, 4'b0000);
    chk("rst_data", reg_data, 8'h00);
    chk("rst_clr", reg_clr, 1'b1);
    tick();
    async_rst = 1'b0;

    // Single write
    tick();
    req = 4'b0001; wdata[7:0] = 8'hA5;
    tick(); at_neg();
    chk("sw_load", reg_load, 1'b1);
    chk("sw_data", reg_data, 8'hA5);
    tick(); at_neg();
    chk("sw_ack", ack, 4'b0001);
    chk("sw_rdata", rdata, 8'hA5);
    chk("sw_owner", owner, 2'd0);
    tick();

    // Round robin over all four requesters
    do_reset(2);
    wdata = 32'h44332211; req = 4'b1111;
    last_n = 0;
    for (int n = 1; n <= 12; n++) begin
      tick(); at_neg();
      if (ack != 4'b0000) begin
        acks.push_back(int'(ack));
        last_n = n;
      end
    end
    for (int i = 0; i < 4; i++) chk("rr_order", (i < acks.size()) ? acks[i] : 0, 32'd1 << i);
    chk("rr_last_cycle", last_n, 32'd11);
    chk("rr_rdata", rdata, 8'h44);

    // Clear has priority over a simultaneous write
    tick();
    req = 4'b0100; wdata[23:16] = 8'h5A;
    tick_n(3); at_neg();
    chk("cp_pre", rdata, 8'h5A);
    clr_req = 1'b1; req = 4'b0010; wdata[15:8] = 8'h77;
    tick(); at_neg();
    chk("cp_clr", reg_clr, 1'b1);
    chk("cp_noload", reg_load, 1'b0);
    tick(); at_neg();
    chk("cp_clr_ack", clr_ack, 1'b1);
    chk("cp_rdata0", rdata, 8'h00);
    tick(); tick(); at_neg();
    chk("cp_wr_owner", owner, 2'd1);
    chk("cp_wr_load", reg_load, 1'b1);
    tick(); at_neg();
    chk("cp_ack", ack, 4'b0010);
    chk("cp_rdata", rdata, 8'h77);
    tick();

    // Reset during WRITE aborts it and rewinds the pointer
    req = 4'b0001; wdata[7:0] = 8'h99;
    tick();
    async_rst = 1'b1;
    at_neg();
    chk("rw_load", reg_load, 1'b0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_ack", ack, 4'b0000);
    tick(); at_neg();
    chk("rw_rdata", rdata, 8'h00);
    tick();
    async_rst = 1'b0; req = 4'b1110; wdata = 32'h0D0C0B00;
    tick(); at_neg();
    chk("rw_ptr0", owner, 2'd1);
    tick_n(12);

    // Inputs changing during the grant do not matter
    req = 4'b0100; wdata[23:16] = 8'hC3;
    tick(); at_neg();
    chk("ic_owner", owner, 2'd2);
    req = 4'b0000; wdata = 32'hFFFFFFFF;
    tick(); at_neg();
    chk("ic_ack", ack, 4'b0100);
    chk("ic_rdata", rdata, 8'hC3);
    tick_n(2);

`ifdef REG_ARB_LOCK_EN
    // Lock keeps requester 0 as owner until released
    do_reset(2);
    lock = 4'b0001; req = 4'b0011; wdata = 32'h00002010;
    zeros = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (zeros < 3) req[0] = 1'b1;
      at_neg();
      if (reg_load) begin
        owners.push_back(int'(owner));
        if (owner == 2'd0) zeros++;
        if (zeros == 3) lock = 4'b0000;
      end
    end
    for (int i = 0; i < 4; i++) chk("lk_order", (i < owners.size()) ? owners[i] : 9, (i < 3) ? 0 : 1);
`endif

    // Randomized traffic, clears and mid-transaction resets
    do_reset(2);
    for (int it = 0; it < 1500; it++) begin
      tick();
      wdata = 32'($urandom());
      if ($urandom_range(0, 3) == 0) req = req | N'($urandom());
      if ($urandom_range(0, 19) == 0) clr_req = 1'b1;
`ifdef REG_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '0;
`endif
      if ($urandom_range(0, 299) == 0) begin
        async_rst = 1'b1;
        tick_n(2);
        async_rst = 1'b0;
      end
    end
    tick_n(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
